look_ahead_borrow_subtractor_pipelined: RTL and testbench

- Pipelined N-bit subtractor, the inverse datapath of the team's 16-bit look-ahead carry adder: Diff = A - B - Borrow_In.
- Uses look-ahead borrow generation instead of carry generation.
- Two-stage pipeline with valid/ready handshakes on both sides, so it can sit between streaming producers and consumers in the arithmetic library.
- Also flags signed overflow and zero results for downstream ALU and comparator logic.

---
 rtl/look_ahead_borrow_pkg.sv | 14 +
 rtl/look_ahead_borrow_block_4_bit.sv | 38 +++
 rtl/look_ahead_borrow_subtractor_pipelined.sv | 158 +++++++++++++++
 tb/tb_look_ahead_borrow_subtractor_pipelined.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/look_ahead_borrow_pkg.sv
// Shared constants and helpers for the pipelined look-ahead borrow subtractor.
// The stage payload and result structs are declared inside the top module,
// because their field widths follow the WIDTH/SPLIT parameters of each instance.
package look_ahead_borrow_pkg;

  // Width of one look-ahead borrow group.
  localparam int GROUP_WIDTH = 4;

  // Borrow out of a group from its generate/propagate and the borrow into it.
  function automatic logic next_borrow(input logic g, input logic p, input logic b_in);
    return g | (p & b_in);
  endfunction

endpackage : look_ahead_borrow_pkg

// File: rtl/look_ahead_borrow_block_4_bit.sv
// Combinational 4-bit subtract slice: diff = a - b - borrow_i.
// A bit generates a borrow when a=0,b=1 and passes an incoming borrow when
// a==b. Every internal borrow is expanded directly from the slice inputs, so
// no borrow ripples through the slice.
module look_ahead_borrow_block_4_bit
  import look_ahead_borrow_pkg::*;
(
  input  logic [GROUP_WIDTH-1:0] a_i,
  input  logic [GROUP_WIDTH-1:0] b_i,
  input  logic                   borrow_i,
  output logic [GROUP_WIDTH-1:0] diff_o,
  output logic                   borrow_o,
  output logic                   group_g_o,
  output logic                   group_p_o
);

  logic [GROUP_WIDTH-1:0] g;
  logic [GROUP_WIDTH-1:0] p;
  logic [GROUP_WIDTH-1:0] bw;

  // Bit generate/propagate, expanded borrow terms, group terms and difference.
  always_comb begin
    g = ~a_i & b_i;
    p = ~(a_i ^ b_i);

    bw[0] = borrow_i;
    bw[1] = g[0] | (p[0] & borrow_i);
    bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & borrow_i);
    bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & borrow_i);

    group_g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    group_p_o = &p;
    borrow_o  = group_g_o | (group_p_o & borrow_i);

    diff_o = a_i ^ b_i ^ bw;
  end

endmodule : look_ahead_borrow_block_4_bit

// File: rtl/look_ahead_borrow_subtractor_pipelined.sv
// Two-stage pipelined subtractor: Diff = A - B - Borrow_In (mod 2^WIDTH).
// Stage 1 resolves the low SPLIT bits and the borrow into bit SPLIT.
// Stage 2 resolves the upper bits and the flags.
// The stages use valid/ready handshakes. In_Ready is combinational from
// Out_Ready, so there is no skid buffer, and at most two beats are in flight.
module look_ahead_borrow_subtractor_pipelined
  import look_ahead_borrow_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPLIT = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data_A_In,
  input  logic [WIDTH-1:0] Data_B_In,
  input  logic             Borrow_In,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Diff_Out,
  output logic             Borrow_Out,
  output logic             Overflow_Out,
  output logic             Zero_Out,
  output logic             Out_Valid,
  input  logic             Out_Ready
);

  localparam int HI_W      = WIDTH - SPLIT;
  localparam int LO_GROUPS = SPLIT / GROUP_WIDTH;
  localparam int HI_GROUPS = HI_W / GROUP_WIDTH;

  if ((WIDTH % GROUP_WIDTH) != 0 || (SPLIT % GROUP_WIDTH) != 0 || SPLIT <= 0 || SPLIT >= WIDTH)
  begin : g_bad_params
    $error("look_ahead_borrow_subtractor_pipelined: WIDTH and SPLIT must be multiples of 4 with 0 < SPLIT < WIDTH");
  end

  typedef struct packed {
    logic [SPLIT-1:0] lo_diff;
    logic             mid_borrow;
    logic [HI_W-1:0]  a_hi;
    logic [HI_W-1:0]  b_hi;
    logic             a_msb;
    logic             b_msb;
  } stage1_payload_t;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;
  } result_t;

  stage1_payload_t s1_d, s1_q;
  result_t         res_d, res_q;
  logic            s1_valid_q, s2_valid_q;
  logic            s1_advance, s2_advance;

  // Stage 1 look-ahead slices over the low SPLIT bits.
  logic [LO_GROUPS:0]   lo_borrow;
  logic [LO_GROUPS-1:0] lo_g, lo_p, lo_bout;
  logic [SPLIT-1:0]     lo_diff;

  assign lo_borrow[0] = Borrow_In;

  for (genvar k = 0; k < LO_GROUPS; k++) begin : g_lo
    look_ahead_borrow_block_4_bit u_blk (
      .a_i      (Data_A_In[k*GROUP_WIDTH +: GROUP_WIDTH]),
      .b_i      (Data_B_In[k*GROUP_WIDTH +: GROUP_WIDTH]),
      .borrow_i (lo_borrow[k]),
      .diff_o   (lo_diff[k*GROUP_WIDTH +: GROUP_WIDTH]),
      .borrow_o (lo_bout[k]),
      .group_g_o(lo_g[k]),
      .group_p_o(lo_p[k])
    );
    assign lo_borrow[k+1] = next_borrow(lo_g[k], lo_p[k], lo_borrow[k]);
  end

  // Stage 2 look-ahead slices over the upper bits, fed by the registered mid borrow.
  logic [HI_GROUPS:0]   hi_borrow;
  logic [HI_GROUPS-1:0] hi_g, hi_p, hi_bout;
  logic [HI_W-1:0]      hi_diff;

  assign hi_borrow[0] = s1_q.mid_borrow;

  for (genvar k = 0; k < HI_GROUPS; k++) begin : g_hi
    look_ahead_borrow_block_4_bit u_blk (
      .a_i      (s1_q.a_hi[k*GROUP_WIDTH +: GROUP_WIDTH]),
      .b_i      (s1_q.b_hi[k*GROUP_WIDTH +: GROUP_WIDTH]),
      .borrow_i (hi_borrow[k]),
      .diff_o   (hi_diff[k*GROUP_WIDTH +: GROUP_WIDTH]),
      .borrow_o (hi_bout[k]),
      .group_g_o(hi_g[k]),
      .group_p_o(hi_p[k])
    );
    assign hi_borrow[k+1] = next_borrow(hi_g[k], hi_p[k], hi_borrow[k]);
  end

  // The group-to-group chain above already produces each slice's ripple
  // borrow-out, so those outputs are collected here only to keep them visible.
  logic unused_group_borrows;
  assign unused_group_borrows = ^{lo_bout, hi_bout};

  // Handshake: a stage may take new data when it is empty or being drained.
  assign s2_advance = !s2_valid_q || Out_Ready;
  assign s1_advance = !s1_valid_q || s2_advance;
  assign In_Ready   = s1_advance;

  // Assemble the stage 1 payload from the incoming operands.
  always_comb begin
    s1_d            = '0;
    s1_d.lo_diff    = lo_diff;
    s1_d.mid_borrow = lo_borrow[LO_GROUPS];
    s1_d.a_hi       = Data_A_In[WIDTH-1:SPLIT];
    s1_d.b_hi       = Data_B_In[WIDTH-1:SPLIT];
    s1_d.a_msb      = Data_A_In[WIDTH-1];
    s1_d.b_msb      = Data_B_In[WIDTH-1];
  end

  // Form the final difference and its flags from the stage 1 payload.
  always_comb begin
    res_d          = '0;
    res_d.diff     = {hi_diff, s1_q.lo_diff};
    res_d.borrow   = hi_borrow[HI_GROUPS];
    res_d.overflow = (s1_q.a_msb != s1_q.b_msb) && (res_d.diff[WIDTH-1] != s1_q.a_msb);
    res_d.zero     = (res_d.diff == '0);
  end

  // Stage 1 register: capture a beat on input transfer.
  // NOTE: state registers use non-blocking assignments. Every register then
  // samples its pre-edge value, and the two stages shift in lockstep.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_advance) begin
      s1_valid_q <= In_Valid;
      if (In_Valid) s1_q <= s1_d;
    end
  end

  // Stage 2 register: load the result when stage 1 holds a beat and the output can move.
  // The result is held while Out_Valid=1 and Out_Ready=0, so the outputs stay stable.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
    end else if (s2_advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) res_q <= res_d;
    end
  end

  assign Diff_Out     = res_q.diff;
  assign Borrow_Out   = res_q.borrow;
  assign Overflow_Out = res_q.overflow;
  assign Zero_Out     = res_q.zero;
  assign Out_Valid    = s2_valid_q;

endmodule : look_ahead_borrow_subtractor_pipelined

// File: tb/tb_look_ahead_borrow_subtractor_pipelined.sv
// Scoreboard bench for the pipelined look-ahead borrow subtractor (16/8 configuration).
module tb_look_ahead_borrow_subtractor_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        bin;
  logic        in_valid, in_ready;
  logic [15:0] diff;
  logic        borrow, ovf, zero;
  logic        out_valid, out_ready;

  typedef struct {
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  look_ahead_borrow_subtractor_pipelined #(.WIDTH(16), .SPLIT(8)) dut (
    .Clock       (clk),
    .Reset       (rst),
    .Data_A_In   (a),
    .Data_B_In   (b),
    .Borrow_In   (bin),
    .In_Valid    (in_valid),
    .In_Ready    (in_ready),
    .Diff_Out    (diff),
    .Borrow_Out  (borrow),
    .Overflow_Out(ovf),
    .Zero_Out    (zero),
    .Out_Valid   (out_valid),
    .Out_Ready   (out_ready)
  );

  // Reference: unsigned 17-bit subtraction for diff/borrow, signed integer range for overflow.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
    exp_t        m;
    logic [16:0] full;
    int          r;
    full     = {1'b0, ma} - {1'b0, mb} - {16'h0, mbin};
    m.diff   = full[15:0];
    m.borrow = full[16];
    r        = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    m.ovf    = (r > 32767) || (r < -32768);
    m.zero   = (m.diff == 16'h0000);
    return m;
  endfunction

  function automatic string fmt(input logic [15:0] d, input logic bo, input logic o, input logic z);
    return $sformatf("diff=%h borrow=%b ovf=%b zero=%b", d, bo, o, z);
  endfunction

  function automatic vec_t mkvec(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                                 input logic [15:0] d, input logic bo, input logic o, input logic z);
    vec_t v;
    v.a = va; v.b = vb; v.bin = vbin;
    v.e.diff = d; v.e.borrow = bo; v.e.ovf = o; v.e.zero = z;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_valids: got out_valid=%b in_ready=%b, expected out_valid=0 in_ready=1", out_valid, in_ready);
    end
    n_checks++;
    if (diff !== 16'h0000 || borrow !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %s, expected %s", fmt(diff, borrow, ovf, zero), fmt(16'h0, 0, 0, 0));
    end
  endtask

  // Single beats with an empty pipeline: checks exact 2-cycle latency and the values.
  task automatic test_directed();
    vec_t vecs[$];
    exp_t e;
    vecs.push_back(mkvec(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkvec(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkvec(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkvec(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mkvec(16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkvec(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mkvec(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0));
    foreach (vecs[i]) begin
      @(negedge clk);
      a = vecs[i].a; b = vecs[i].b; bin = vecs[i].bin; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_%0d_in_ready: got %b, expected 1", i, in_ready);
      end else sb.push_back(vecs[i].e);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_%0d_early: got out_valid=%b one cycle after transfer, expected 0", i, out_valid);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL directed_%0d_latency: got out_valid=%b two cycles after transfer, expected 1", i, out_valid);
      end else begin
        e = sb.pop_front();
        if (diff !== e.diff || borrow !== e.borrow || ovf !== e.ovf || zero !== e.zero) begin
          n_fail++;
          $display("FAIL directed_%0d: got %s, expected %s", i, fmt(diff, borrow, ovf, zero),
                   fmt(e.diff, e.borrow, e.ovf, e.zero));
        end
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_%0d_dup: got out_valid=%b after the beat left, expected 0", i, out_valid);
      end
    end
    sb.delete();
  endtask

  // Continuous stream with a ready consumer: one beat per cycle, consecutive outputs.
  task automatic test_back_to_back();
    int   sent = 0, recv = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
    exp_t e;
    while ((sent < 8 || recv < 8) && cyc < 40) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (sent < 8);
      a = 16'(16'h1111 * (sent + 1)); b = 16'(16'h0F0F + sent * 16'h2345); bin = 1'(sent);
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: got an output beat %s, expected none", fmt(diff, borrow, ovf, zero));
        end else begin
          e = sb.pop_front();
          if (diff !== e.diff || borrow !== e.borrow || ovf !== e.ovf || zero !== e.zero) begin
            n_fail++;
            $display("FAIL b2b_beat_%0d: got %s, expected %s", recv, fmt(diff, borrow, ovf, zero),
                     fmt(e.diff, e.borrow, e.ovf, e.zero));
          end
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        recv++;
      end
      if (in_valid) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready_%0d: got %b, expected 1", sent, in_ready);
        end else begin
          sb.push_back(model(a, b, bin));
          sent++;
        end
      end
      cyc++;
    end
    n_checks++;
    if (recv != 8 || last_cyc - first_cyc != 7) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d beats over %0d cycles, expected 8 over 8", recv, last_cyc - first_cyc + 1);
    end
    in_valid = 1'b0;
    sb.delete();
  endtask

  // Stall the consumer: only two beats fit, outputs stay frozen, then all four drain in order.
  task automatic test_backpressure();
    logic [15:0] va[4] = '{16'h0010, 16'h8000, 16'h0000, 16'h4321};
    logic [15:0] vb[4] = '{16'h0011, 16'h7FFF, 16'h0000, 16'h1234};
    logic        vbin[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int          sent = 0, recv = 0, cyc = 0;
    logic        seen = 1'b0;
    logic [15:0] held = '0;
    exp_t        e;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; a = va[sent]; b = vb[sent]; bin = vbin[sent];
      #1;
      if (out_valid) begin
        if (seen) begin
          n_checks++;
          if (diff !== held) begin
            n_fail++;
            $display("FAIL bp_stable: got diff=%h while stalled, expected %h", diff, held);
          end
        end
        seen = 1'b1;
        held = diff;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, bin));
        sent++;
      end
    end
    n_checks++;
    if (sent != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_capacity: got accepts=%0d in_ready=%b out_valid=%b, expected 2 0 1", sent, in_ready, out_valid);
    end
    while (recv < 4 && cyc < 40) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (sent < 4);
      if (sent < 4) begin a = va[sent]; b = vb[sent]; bin = vbin[sent]; end
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: got an output beat %s, expected none", fmt(diff, borrow, ovf, zero));
        end else begin
          e = sb.pop_front();
          if (diff !== e.diff || borrow !== e.borrow || ovf !== e.ovf || zero !== e.zero) begin
            n_fail++;
            $display("FAIL bp_beat_%0d: got %s, expected %s", recv, fmt(diff, borrow, ovf, zero),
                     fmt(e.diff, e.borrow, e.ovf, e.zero));
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, bin));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (recv != 4 || sb.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d beats, %0d pending, out_valid=%b, expected 4 0 0", recv, sb.size(), out_valid);
    end
    sb.delete();
  endtask

  // Random operands with random valid/ready; every output transfer is scored.
  task automatic test_random();
    int          sent = 0, cyc = 0;
    logic        stalled = 1'b0;
    logic [15:0] held = '0;
    exp_t        e;
    while ((sent < 2000 || sb.size() != 0) && cyc < 30000) begin
      @(negedge clk);
      in_valid = (sent < 2000) && ($urandom_range(0, 3) != 0);
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = b;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || diff !== held) begin
          n_fail++;
          $display("FAIL rand_hold: got out_valid=%b diff=%h, expected 1 %h", out_valid, diff, held);
        end
      end
      stalled = out_valid && !out_ready;
      held    = diff;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: got an output beat %s, expected none", fmt(diff, borrow, ovf, zero));
        end else begin
          e = sb.pop_front();
          if (diff !== e.diff || borrow !== e.borrow || ovf !== e.ovf || zero !== e.zero) begin
            n_fail++;
            $display("FAIL rand_beat: got %s, expected %s", fmt(diff, borrow, ovf, zero),
                     fmt(e.diff, e.borrow, e.ovf, e.zero));
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, bin));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (sent != 2000 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rand_timeout: got %0d sent, %0d pending, expected 2000 0", sent, sb.size());
    end
    sb.delete();
  endtask

  // Reset with beats in flight: valids and outputs clear at once, nothing stale appears later.
  task automatic test_reset_midstream();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; a = 16'h0003; b = 16'h0001; bin = 1'b0;
    end
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || diff !== 16'h0002) begin
      n_fail++;
      $display("FAIL midrst_loaded: got out_valid=%b diff=%h, expected 1 0002", out_valid, diff);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || diff !== 16'h0000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_async: got out_valid=%b diff=%h in_ready=%b, expected 0 0000 1", out_valid, diff, in_ready);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_stale_%0d: got out_valid=%b, expected 0", c, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule : tb_look_ahead_borrow_subtractor_pipelined
